// File: rtl/mem_refill_arbiter.sv
// Arbitrates the shared memory port between I-cache refills and D-cache refills/writebacks.
// Each grant runs one uninterrupted fixed-length burst; ties alternate round-robin.
module mem_refill_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 4,
    localparam int unsigned BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [BEAT_W-1:0] d_beat,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned STRIDE = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(BURST_LEN * STRIDE);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(STRIDE);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StIBurst, StDBurst} state_e;
    typedef enum logic {GntI, GntD} gnt_e;

    state_e              r_state, w_state_nxt;
    gnt_e                r_last_gnt, w_last_gnt_nxt;
    logic                r_mem_valid, w_mem_valid_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [BEAT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;

    logic w_last_beat;
    logic w_i_active;
    logic w_d_active;

    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    assign w_i_active  = (r_state == StIBurst);
    assign w_d_active  = (r_state == StDBurst);

    always_comb begin
        w_state_nxt     = r_state;
        w_last_gnt_nxt  = r_last_gnt;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_beat_cnt_nxt  = r_beat_cnt;
        case (r_state)
            StIdle: begin
                // On a tie the requester that did not win last time gets the port.
                if (i_req && (!d_req || r_last_gnt == GntD)) begin
                    w_state_nxt     = StIBurst;
                    w_last_gnt_nxt  = GntI;
                    w_mem_valid_nxt = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = i_addr & ALIGN_MASK;
                    w_beat_cnt_nxt  = '0;
                end else if (d_req) begin
                    w_state_nxt     = StDBurst;
                    w_last_gnt_nxt  = GntD;
                    w_mem_valid_nxt = 1'b1;
                    w_mem_we_nxt    = d_we;
                    w_mem_addr_nxt  = d_addr & ALIGN_MASK;
                    w_beat_cnt_nxt  = '0;
                end
            end
            StIBurst, StDBurst: begin
                if (mem_ready) begin
                    if (w_last_beat) begin
                        w_state_nxt     = StIdle;
                        w_mem_valid_nxt = 1'b0;
                        w_mem_we_nxt    = 1'b0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
                        w_mem_addr_nxt = r_mem_addr + ADDR_STEP;
                    end
                end
            end
            default: begin
                w_state_nxt     = StIdle;
                w_mem_valid_nxt = 1'b0;
                w_mem_we_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_last_gnt  <= GntI;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_gnt  <= w_last_gnt_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = d_wdata;
    assign d_beat    = r_beat_cnt;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign i_rvalid  = w_i_active & mem_ready;
    // Writeback beats return nothing to the D-cache.
    assign d_rvalid  = w_d_active & mem_ready & ~r_mem_we;
    assign i_done    = w_i_active & mem_ready & w_last_beat;
    assign d_done    = w_d_active & mem_ready & w_last_beat;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Scoreboard bench for mem_refill_arbiter: stimulus queues expected beats,
// a negedge monitor pops and checks each completed memory beat.
module tb_mem_refill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]  d_beat;
    logic        i_rvalid, i_done, d_rvalid, d_done, mem_valid, mem_we;

    always #5 clk = ~clk;

    mem_refill_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_beat    (d_beat),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_done    (d_done),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  beat;
        logic        last;
        int          gap;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    n_idone = 0;
    int    n_ddone = 0;
    int    last_done_cyc = -100;
    bit    wb_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] wd_model(input logic [1:0] b);
        return 32'hD0D0_0000 | {30'd0, b};
    endfunction

    assign mem_rdata = rd_model(mem_addr);
    assign d_wdata   = wd_model(d_beat);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_burst(input logic is_d, input logic we, input logic [31:0] base,
                              input int gap, input int nbeats = 4);
        for (int k = 0; k < nbeats; k++) begin
            beat_t e;
            e.is_d = is_d;
            e.we   = we;
            e.addr = base + 32'(4 * k);
            e.beat = 2'(k);
            e.last = (k == 3);
            e.gap  = (k == 0) ? gap : 0;
            exp_q.push_back(e);
        end
    endtask

    // Returns at posedge+1 of the cycle after the done pulse.
    task automatic wait_done(input logic is_d, input int target, input string name);
        int n;
        n = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            n = is_d ? n_ddone : n_idone;
            if (n >= target) break;
        end
        check({name, "_done_count"}, n, target);
        @(posedge clk);
        #1;
        check({name, "_idle_valid"}, {31'd0, mem_valid}, 32'd0);
        check({name, "_idle_we"}, {31'd0, mem_we}, 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst_n && mem_valid && mem_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: addr 0x%08h seen, no beat expected", mem_addr);
            end else begin
                e = exp_q.pop_front();
                check("beat_addr", mem_addr, e.addr);
                check("beat_we", {31'd0, mem_we}, {31'd0, e.we});
                check("beat_idx", {30'd0, d_beat}, {30'd0, e.beat});
                check("i_rvalid", {31'd0, i_rvalid}, {31'd0, !e.is_d});
                check("d_rvalid", {31'd0, d_rvalid}, {31'd0, e.is_d && !e.we});
                check("i_done", {31'd0, i_done}, {31'd0, !e.is_d && e.last});
                check("d_done", {31'd0, d_done}, {31'd0, e.is_d && e.last});
                if (!e.is_d) check("i_rdata", i_rdata, rd_model(e.addr));
                if (e.is_d && !e.we) check("d_rdata", d_rdata, rd_model(e.addr));
                if (e.we) check("mem_wdata", mem_wdata, wd_model(e.beat));
                if (e.gap != 0) check("grant_gap", 32'(cyc - last_done_cyc), 32'(e.gap));
            end
        end else if (i_rvalid || d_rvalid || i_done || d_done) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_out: irv=%0b drv=%0b idone=%0b ddone=%0b, required all 0",
                     i_rvalid, d_rvalid, i_done, d_done);
        end
        if (i_done) n_idone++;
        if (d_done) n_ddone++;
        if (i_done || d_done) last_done_cyc = cyc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_beat", {30'd0, d_beat}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {31'd0, mem_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Tie right after reset: D wins, then I after one idle cycle.
        i_addr = 32'h0000_3004; d_addr = 32'h0000_201C; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        push_burst(1'b1, 1'b0, 32'h0000_2010, 0);
        push_burst(1'b0, 1'b0, 32'h0000_3000, 2);
        wait_done(1'b1, 1, "tie_d");
        d_req = 1'b0;
        wait_done(1'b0, 1, "tie_i");
        i_req = 1'b0;

        // Single I refill with an unaligned miss address.
        i_addr = 32'h0000_1008; i_req = 1'b1;
        push_burst(1'b0, 1'b0, 32'h0000_1000, 0);
        wait_done(1'b0, 2, "single_i");
        i_req = 1'b0;

        // D writeback under a stalling memory.
        d_we = 1'b1; d_addr = 32'h0000_2000; mem_ready = 1'b0; d_req = 1'b1;
        push_burst(1'b1, 1'b1, 32'h0000_2000, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 7; k++) begin
            mem_ready = wb_pat[k];
            @(posedge clk);
            #1;
        end
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1;
        check("wb_done_count", n_ddone, 2);
        check("wb_idle_valid", {31'd0, mem_valid}, 32'd0);

        // Both held continuously: strict alternation D, I, D, I.
        d_addr = 32'h0000_6000; d_req = 1'b1;
        push_burst(1'b1, 1'b0, 32'h0000_6000, 0);
        @(posedge clk);
        #1;
        i_addr = 32'h0000_7000; i_req = 1'b1;
        d_addr = 32'h0000_6040;
        push_burst(1'b0, 1'b0, 32'h0000_7000, 2);
        push_burst(1'b1, 1'b0, 32'h0000_6040, 2);
        push_burst(1'b0, 1'b0, 32'h0000_7000, 2);
        wait_done(1'b1, 3, "alt_d1");
        wait_done(1'b0, 3, "alt_i1");
        wait_done(1'b1, 4, "alt_d2");
        d_req = 1'b0;
        wait_done(1'b0, 4, "alt_i2");
        i_req = 1'b0;

        // i_req dropped after the first beat: burst still completes, no regrant.
        i_addr = 32'h0000_4000; i_req = 1'b1;
        push_burst(1'b0, 1'b0, 32'h0000_4000, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        wait_done(1'b0, 5, "drop_i");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_regrant", {31'd0, mem_valid}, 32'd0);
        end

        // Reset during beat 2 aborts the burst asynchronously.
        @(posedge clk);
        #1;
        i_addr = 32'h0000_5000; i_req = 1'b1;
        push_burst(1'b0, 1'b0, 32'h0000_5000, 0, 2);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, mem_valid}, 32'd0);
        check("abort_we", {31'd0, mem_we}, 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", n_idone, 5);
        rst_n = 1'b1;
        push_burst(1'b0, 1'b0, 32'h0000_5000, 0);
        wait_done(1'b0, 6, "post_rst");
        i_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Shares the single external memory port between the I-cache refill engine and the D-cache refill/writeback engine.
- Each granted request runs as a fixed-length burst that is never interrupted.
- Arbitration is round-robin on ties, so neither cache can starve the other.
- Sits between the cache controllers and the memory bus; the caches derive their pipeline cache_stall from their own pending req and the done pulses produced here.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, beat data width in bits; byte stride per beat is DATA_W/8.
- BURST_LEN, 4, beats per burst; must be a power of 2 and at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_req  input  1  I-cache refill request; held until i_done.
- i_addr  input  ADDR_W  I-cache miss address.
- i_rdata  output  DATA_W  read beat to I-cache.
- i_rvalid  output  1  i_rdata valid this cycle.
- i_done  output  1  one-cycle pulse on the final I beat.
- d_req  input  1  D-cache request; held until d_done.
- d_we  input  1  1 = writeback burst, 0 = refill.
- d_addr  input  ADDR_W  D-cache line address.
- d_wdata  input  DATA_W  write data for the beat indexed by d_beat.
- d_beat  output  clog2(BURST_LEN), minimum 1  current beat index.
- d_rdata  output  DATA_W  read beat to D-cache.
- d_rvalid  output  1  d_rdata valid this cycle.
- d_done  output  1  one-cycle pulse on the final D beat.
- mem_valid  output  1  beat request to memory.
- mem_we  output  1  beat is a write.
- mem_addr  output  ADDR_W  beat address.
- mem_wdata  output  DATA_W  beat write data.
- mem_ready  input  1  memory completes the current beat this cycle; read data is valid with it.
- mem_rdata  input  DATA_W  read data.

Behaviour:
- Reset (async on rst_n low): state IDLE; mem_valid=0, mem_we=0, mem_addr=0, beat_cnt=0, last_gnt=I. All combinational outputs then evaluate to 0.
- FSM states: IDLE, I_BURST, D_BURST.
- IDLE, arbitration:
  - Only i_req set: grant I.
  - Only d_req set: grant D.
  - Both set: grant the requester not equal to last_gnt. After reset, D wins the first tie.
  - Neither set: stay in IDLE.
- On grant (registered, effective at the next edge):
  - state = granted burst state; mem_valid=1.
  - mem_addr = requester address with its low log2(BURST_LEN*DATA_W/8) bits cleared.
  - mem_we = d_we for D, 0 for I.
  - beat_cnt=0; last_gnt = granted requester.
- During a burst:
  - mem_valid stays 1.
  - Each cycle with mem_ready=1 completes one beat: at the edge, beat_cnt increments and mem_addr increments by DATA_W/8.
  - mem_ready=0 holds all registers.
- Combinational data paths:
  - mem_wdata = d_wdata.
  - d_beat = beat_cnt.
  - i_rdata and d_rdata = mem_rdata.
  - i_rvalid = I_BURST & mem_ready.
  - d_rvalid = D_BURST & mem_ready & !mem_we. No rvalid is produced on writeback beats.
- Last beat (beat_cnt = BURST_LEN-1 & mem_ready):
  - The requester's done pulses in the same cycle.
  - Next edge: state=IDLE, mem_valid=0, mem_we=0. mem_addr holds its value (don't-care).
  - The requester deasserts req in the cycle after done.
- IDLE lasts at least one cycle between bursts, so the earliest possible re-grant is 2 cycles after done.
- Deasserting req mid-burst is ignored; the burst completes.
- i_addr, d_addr and d_we are sampled only at grant.
- BURST_LEN=1: each burst is one beat; beat_cnt stays 0.
- Reset mid-burst aborts immediately: mem_valid drops asynchronously and no done pulse is produced.
- A req still high in the done cycle must not cause a re-grant before IDLE; it is arbitrated normally once in IDLE.

Test Plan:
- Single I refill, i_addr=0x1008, mem_ready=1 every cycle:
  - mem_addr sequence 0x1000, 0x1004, 0x1008, 0x100C.
  - 4 i_rvalid pulses; i_done on the 4th; mem_valid low the next cycle.
- i_req and d_req both raised in the first cycle after reset, d_we=0:
  - D burst runs first, then one IDLE cycle, then the I burst.
  - last_gnt ends as I.
- D writeback, d_addr=0x2000, mem_ready pattern 1,0,0,1,1,0,1:
  - d_beat advances only on ready cycles.
  - mem_wdata tracks d_wdata for the indexed beat; no d_rvalid.
  - d_done coincides with the 4th ready.
- D re-requests immediately after d_done while i_req is held:
  - Next grant goes to I.
  - The following tie goes to D, giving a strict alternation.
- i_req dropped after beat 1:
  - Burst continues to 4 beats and i_done pulses.
  - No new grant while both reqs are low.
- rst_n pulsed low mid-burst at beat 2:
  - mem_valid, mem_we and mem_addr go to 0 asynchronously; no done pulse.
  - After release with i_req high, a fresh burst starts at beat 0.
